// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default framing parameters
// and the half-bit sampling offset used by both transmitter and receiver.
package uart_pkg;

  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int DEFAULT_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  // Mid-bit point measured from a bit edge; OVERSAMPLE is always even.
  function automatic int half_bit_offset(input int oversample);
    return oversample / 2;
  endfunction

  localparam int HALF_BIT = half_bit_offset(DEFAULT_OVERSAMPLE);

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line plus falling-edge detect
// taken from the synchronised value and its one-cycle-delayed copy.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_in,
  output logic rx_s,
  output logic fall_pulse
);

  logic rx_meta;
  logic rx_prev;

  // Every stage resets high so a released reset on an idle line never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign fall_pulse = rx_prev & ~rx_s;

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage (8N1 by default, mid-bit single-sample decisions).
// Define UART_RX_PARITY_EN to expect an even-parity bit and expose parity_err.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int DATA_BITS  = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = DATA_BITS + 1;
`else
  localparam int FRAME_BITS = DATA_BITS;
`endif

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(half_bit_offset(OVERSAMPLE) - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_BITS - 1);

  logic                 rx_s;
  logic                 fall_pulse;
  rx_state_t            state;
  logic [CNT_W-1:0]     sample_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bit;
`endif

  uart_rx_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_in      (rx_in),
    .rx_s       (rx_s),
    .fall_pulse (fall_pulse)
  );

  // The sample counter restarts at every decision point, so each later sample
  // lands a whole bit period after the mid-start sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sample_cnt <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (fall_pulse) begin
            state      <= START;
            busy       <= 1'b1;
            sample_cnt <= '0;
          end
        end

        START: begin
          if (sample_cnt == HALF_LAST) begin
            sample_cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end else begin
            sample_cnt <= sample_cnt + 1'b1;
          end
        end

        DATA: begin
          if (sample_cnt == BIT_LAST) begin
            sample_cnt <= '0;
`ifdef UART_RX_PARITY_EN
            if (bit_idx == IDX_W'(DATA_BITS)) begin
              parity_bit <= rx_s;
            end else begin
              shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            end
`else
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
`endif
            if (bit_idx == IDX_LAST) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            sample_cnt <= sample_cnt + 1'b1;
          end
        end

        STOP: begin
          if (sample_cnt == BIT_LAST) begin
            sample_cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
              if ((^shift_reg) != parity_bit) begin
                parity_err <= 1'b1;
              end else begin
                data_out   <= shift_reg;
                data_valid <= 1'b1;
              end
`else
              data_out   <= shift_reg;
              data_valid <= 1'b1;
`endif
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            sample_cnt <= sample_cnt + 1'b1;
          end
        end

        // A held-low line (break) must return high before a new start is armed.
        WAIT_IDLE: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed testbench for uart_receiver; honours UART_RX_PARITY_EN when defined.
module tb_uart_receiver;

  localparam int OS = 16;
  localparam int DB = 8;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = DB + 1;
`else
  localparam int NBITS = DB;
`endif
  // rx_in fall -> data_valid: 2 sync + half bit + (NBITS+1) bits + 1 register = 155 (171 with parity)
  localparam int VALID_LAT = 2 + OS / 2 + OS * (NBITS + 1) + 1;
  localparam int STOP_OFS  = OS * (NBITS + 1);
  localparam int FRAME_LEN = STOP_OFS + OS;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_in = 1'b1;
  logic [DB-1:0] data_out;
  logic          data_valid;
  logic          frame_err;
  logic          busy;
`ifdef UART_RX_PARITY_EN
  logic          parity_err;
`endif

  uart_receiver #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            checks = 0;
  int            passes = 0;
  int            fall_cyc = 0;
  int            dv_cyc[$];
  logic [DB-1:0] dv_dat[$];
  int            fe_cyc[$];
  int            pe_cyc[$];
  int            rise_q[$];
  int            fall_q[$];
  int            both_high = 0;
  logic          busy_d = 1'b0;

  // Pulse and busy-edge logger, sampled on the falling edge.
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      dv_cyc.push_back(cyc);
      dv_dat.push_back(data_out);
    end
    if (frame_err === 1'b1) fe_cyc.push_back(cyc);
`ifdef UART_RX_PARITY_EN
    if (parity_err === 1'b1) pe_cyc.push_back(cyc);
`endif
    if (data_valid === 1'b1 && frame_err === 1'b1) both_high++;
    if (busy === 1'b1 && busy_d === 1'b0) rise_q.push_back(cyc);
    if (busy === 1'b0 && busy_d === 1'b1) fall_q.push_back(cyc);
    busy_d = busy;
  end

  task automatic clear_logs();
    dv_cyc.delete();
    dv_dat.delete();
    fe_cyc.delete();
    pe_cyc.delete();
    rise_q.delete();
    fall_q.delete();
  endtask

  task automatic drive(input logic b, input int n);
    rx_in = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_head(input logic [DB-1:0] d);
    fall_cyc = cyc;
    drive(1'b0, OS);
    for (int i = 0; i < DB; i++) drive(d[i], OS);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input int stop_cycles);
    send_head(d);
`ifdef UART_RX_PARITY_EN
    drive(^d, OS);
`endif
    drive(1'b1, stop_cycles);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (data_out !== 8'h00) $display("[TB] FAIL reset_data_out: got %h expected 00", data_out); else passes++;
    checks++; if (data_valid !== 1'b0) $display("[TB] FAIL reset_data_valid: got %b expected 0", data_valid); else passes++;
    checks++; if (frame_err !== 1'b0) $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passes++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 5);
  endtask

  task automatic test_good_frame();
    drive(1'b1, 20);
    clear_logs();
    send_frame(8'hA5, OS);
    drive(1'b1, 10);
    checks++;
    if (dv_cyc.size() != 1) $display("[TB] FAIL good_valid_count: got %0d expected 1", dv_cyc.size());
    else begin
      passes++;
      checks++; if (dv_cyc[0] != fall_cyc + VALID_LAT) $display("[TB] FAIL good_valid_cycle: got %0d expected %0d", dv_cyc[0] - fall_cyc, VALID_LAT); else passes++;
      checks++; if (dv_dat[0] !== 8'hA5) $display("[TB] FAIL good_data: got %h expected a5", dv_dat[0]); else passes++;
    end
    checks++; if (fe_cyc.size() != 0) $display("[TB] FAIL good_frame_err: got %0d pulses expected 0", fe_cyc.size()); else passes++;
    checks++; if (data_out !== 8'hA5) $display("[TB] FAIL good_data_held: got %h expected a5", data_out); else passes++;
    checks++;
    if (rise_q.size() != 1 || fall_q.size() != 1) $display("[TB] FAIL good_busy_edges: got %0d/%0d expected 1/1", rise_q.size(), fall_q.size());
    else begin
      passes++;
      checks++; if (rise_q[0] != fall_cyc + 3) $display("[TB] FAIL good_busy_rise: got %0d expected 3", rise_q[0] - fall_cyc); else passes++;
      checks++; if (fall_q[0] != fall_cyc + VALID_LAT) $display("[TB] FAIL good_busy_fall: got %0d expected %0d", fall_q[0] - fall_cyc, VALID_LAT); else passes++;
    end
  endtask

  task automatic test_false_start();
    clear_logs();
    fall_cyc = cyc;
    drive(1'b0, 4);
    drive(1'b1, 40);
    checks++;
    if (rise_q.size() != 1 || fall_q.size() != 1) $display("[TB] FAIL false_busy_edges: got %0d/%0d expected 1/1", rise_q.size(), fall_q.size());
    else begin
      passes++;
      checks++; if (rise_q[0] != fall_cyc + 3) $display("[TB] FAIL false_busy_rise: got %0d expected 3", rise_q[0] - fall_cyc); else passes++;
      checks++; if (fall_q[0] != fall_cyc + 11) $display("[TB] FAIL false_busy_fall: got %0d expected 11", fall_q[0] - fall_cyc); else passes++;
    end
    checks++; if (dv_cyc.size() != 0) $display("[TB] FAIL false_valid: got %0d pulses expected 0", dv_cyc.size()); else passes++;
    checks++; if (fe_cyc.size() != 0) $display("[TB] FAIL false_frame_err: got %0d pulses expected 0", fe_cyc.size()); else passes++;
  endtask

  task automatic test_frame_error();
    clear_logs();
    send_head(8'h3C);
`ifdef UART_RX_PARITY_EN
    drive(^(8'h3C), OS);
`endif
    drive(1'b0, 40);
    drive(1'b1, 30);
    checks++;
    if (fe_cyc.size() != 1) $display("[TB] FAIL ferr_count: got %0d expected 1", fe_cyc.size());
    else begin
      passes++;
      checks++; if (fe_cyc[0] != fall_cyc + VALID_LAT) $display("[TB] FAIL ferr_cycle: got %0d expected %0d", fe_cyc[0] - fall_cyc, VALID_LAT); else passes++;
    end
    checks++; if (dv_cyc.size() != 0) $display("[TB] FAIL ferr_valid: got %0d pulses expected 0", dv_cyc.size()); else passes++;
    checks++; if (data_out !== 8'hA5) $display("[TB] FAIL ferr_data_held: got %h expected a5", data_out); else passes++;
    checks++; if (rise_q.size() != 1) $display("[TB] FAIL ferr_spurious_start: got %0d busy rises expected 1", rise_q.size()); else passes++;
    checks++;
    if (fall_q.size() != 1) $display("[TB] FAIL ferr_busy_fall_count: got %0d expected 1", fall_q.size());
    else begin
      passes++;
      checks++; if (fall_q[0] != fall_cyc + STOP_OFS + 43) $display("[TB] FAIL ferr_busy_fall: got %0d expected %0d", fall_q[0] - fall_cyc, STOP_OFS + 43); else passes++;
    end
  endtask

  task automatic test_back_to_back();
    int first_fall;
    clear_logs();
    send_frame(8'h00, OS);
    first_fall = fall_cyc;
    send_frame(8'hFF, OS);
    drive(1'b1, 20);
    checks++;
    if (dv_cyc.size() != 2) $display("[TB] FAIL b2b_valid_count: got %0d expected 2", dv_cyc.size());
    else begin
      passes++;
      checks++; if (dv_cyc[0] != first_fall + VALID_LAT) $display("[TB] FAIL b2b_first_cycle: got %0d expected %0d", dv_cyc[0] - first_fall, VALID_LAT); else passes++;
      checks++; if (dv_cyc[1] - dv_cyc[0] != FRAME_LEN) $display("[TB] FAIL b2b_spacing: got %0d expected %0d", dv_cyc[1] - dv_cyc[0], FRAME_LEN); else passes++;
      checks++; if (dv_dat[0] !== 8'h00) $display("[TB] FAIL b2b_data0: got %h expected 00", dv_dat[0]); else passes++;
      checks++; if (dv_dat[1] !== 8'hFF) $display("[TB] FAIL b2b_data1: got %h expected ff", dv_dat[1]); else passes++;
    end
    checks++; if (fe_cyc.size() != 0) $display("[TB] FAIL b2b_frame_err: got %0d pulses expected 0", fe_cyc.size()); else passes++;
  endtask

  task automatic test_reset_midframe();
    clear_logs();
    fall_cyc = cyc;
    drive(1'b0, OS);
    drive(1'b1, OS);
    drive(1'b0, OS);
    drive(1'b1, OS);
    drive(1'b0, OS / 2);
    rst_n = 1'b0;
    rx_in = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 200);
    checks++; if (dv_cyc.size() != 0) $display("[TB] FAIL rstmid_valid: got %0d pulses expected 0", dv_cyc.size()); else passes++;
    checks++; if (fe_cyc.size() != 0) $display("[TB] FAIL rstmid_frame_err: got %0d pulses expected 0", fe_cyc.size()); else passes++;
    checks++; if (data_out !== 8'h00) $display("[TB] FAIL rstmid_data_out: got %h expected 00", data_out); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); else passes++;
    clear_logs();
    send_frame(8'h81, OS);
    drive(1'b1, 20);
    checks++;
    if (dv_cyc.size() != 1) $display("[TB] FAIL rstmid_next_count: got %0d expected 1", dv_cyc.size());
    else begin
      passes++;
      checks++; if (dv_dat[0] !== 8'h81) $display("[TB] FAIL rstmid_next_data: got %h expected 81", dv_dat[0]); else passes++;
      checks++; if (dv_cyc[0] != fall_cyc + VALID_LAT) $display("[TB] FAIL rstmid_next_cycle: got %0d expected %0d", dv_cyc[0] - fall_cyc, VALID_LAT); else passes++;
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    clear_logs();
    send_head(8'h07);
    drive(1'b1, OS);
    drive(1'b1, OS);
    drive(1'b1, 10);
    checks++;
    if (dv_cyc.size() != 1) $display("[TB] FAIL par_good_count: got %0d expected 1", dv_cyc.size());
    else begin
      passes++;
      checks++; if (dv_dat[0] !== 8'h07) $display("[TB] FAIL par_good_data: got %h expected 07", dv_dat[0]); else passes++;
    end
    checks++; if (pe_cyc.size() != 0) $display("[TB] FAIL par_good_perr: got %0d pulses expected 0", pe_cyc.size()); else passes++;
    clear_logs();
    send_head(8'h07);
    drive(1'b0, OS);
    drive(1'b1, OS);
    drive(1'b1, 10);
    checks++;
    if (pe_cyc.size() != 1) $display("[TB] FAIL par_bad_count: got %0d expected 1", pe_cyc.size());
    else begin
      passes++;
      checks++; if (pe_cyc[0] != fall_cyc + VALID_LAT) $display("[TB] FAIL par_bad_cycle: got %0d expected %0d", pe_cyc[0] - fall_cyc, VALID_LAT); else passes++;
    end
    checks++; if (dv_cyc.size() != 0) $display("[TB] FAIL par_bad_valid: got %0d pulses expected 0", dv_cyc.size()); else passes++;
    checks++; if (data_out !== 8'h07) $display("[TB] FAIL par_bad_data_held: got %h expected 07", data_out); else passes++;
  endtask
`endif

  initial begin
    $display("[TB] uart_receiver bench start");
    test_reset();
    test_good_frame();
    test_false_start();
    test_frame_error();
    test_back_to_back();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    checks++; if (both_high != 0) $display("[TB] FAIL valid_and_ferr_together: got %0d cycles expected 0", both_high); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage; consumes the 8N1 bit stream produced by the team's transmitter (idle-high line, start bit, 8 data bits LSB first, stop bit).
- Runs on the same oversampled clock: each bit lasts OVERSAMPLE clk cycles.
- Synchronises the asynchronous line, validates the start bit, samples at mid-bit and presents a byte with a one-cycle valid strobe.

Parameters:
- OVERSAMPLE, 16: clk cycles per bit. Must be an even number of at least 4.
- DATA_BITS, 8: data bits per frame.

Ports:
- clk  input  1  oversampled bit clock (OVERSAMPLE x baud).
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- rx_in  input  1  asynchronous serial line, idle high.
- data_out  output  DATA_BITS  last good byte; held until the next good frame.
- data_valid  output  1  one-cycle pulse when data_out updates.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- busy  output  1  high from start-edge detection until the receiver returns to IDLE.

Behaviour:
- Reset (rst_n=0 at posedge): data_out=0, data_valid=0, frame_err=0, busy=0, state=IDLE, counters=0, both sync flops=1. Reset mid-frame abandons the frame with no pulse.
- Synchroniser: rx_in passes through 2 flops to give rx_s. All decisions use rx_s, so the receiver adds 2 cycles of latency relative to rx_in.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE:
  - Moves to START when rx_s=0 and the previous rx_s=1 (falling edge). Call this cycle T.
  - Sets busy=1 and clears the sample counter.
- START:
  - At T+OVERSAMPLE/2 (T+8), samples rx_s.
  - If rx_s=1, the start is false: return to IDLE, busy=0, no pulse.
  - If rx_s=0, go to DATA.
- DATA:
  - Bit i is sampled at T+8+16*(i+1) and shifted in LSB first.
  - After bit DATA_BITS-1, go to STOP.
- STOP: samples rx_s at T+8+16*(DATA_BITS+1), which is T+152 at defaults.
  - If rx_s=1: in cycle T+153, data_out takes the shifted byte and data_valid=1 for exactly 1 cycle. Return to IDLE, busy=0.
  - If rx_s=0: frame_err=1 for 1 cycle, data_out is unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stays there until rx_s=1, then goes to IDLE (busy=0). This prevents a break condition from being treated as a new start.
- Back-to-back frames: a start edge arriving any time after the stop sample is accepted, including an edge 8 cycles after the stop sample.
- data_valid and frame_err are never both high in the same cycle.
- The sample counter counts 0..OVERSAMPLE-1 and wraps. Its width is $clog2(OVERSAMPLE); the bit index width is $clog2(DATA_BITS+1).
- Mid-frame glitches on data bits are not filtered: single-sample decision only.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - An even-parity bit follows the data bits; STOP moves out one bit (T+168 at defaults).
  - New output port parity_err (1 bit, reset 0).
  - On parity mismatch with a good stop bit: parity_err pulses for 1 cycle, data_valid stays 0 and data_out is unchanged.
  - On a bad stop bit: frame_err takes priority and parity_err stays 0.
- When not defined: no parity bit and no parity_err port; 8N1 timing exactly as above.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding (IDLE/START/DATA/STOP/WAIT_IDLE);
  - default OVERSAMPLE and DATA_BITS;
  - the half-bit offset constant, so the transmitter and receiver use identical values.
- One natural sub-module, uart_rx_sync: the 2-flop synchroniser plus registered falling-edge detect. Outputs rx_s and fall_pulse; both flops reset to 1.

Test Plan:
- Frame for 0xA5 driven at 16 cycles/bit after 20 idle cycles -> data_valid 1 cycle at rx_in fall + 2 + 153; data_out=0xA5; frame_err=0.
- rx_in low for 4 cycles, then high -> busy rises, then clears after the mid-start sample; no data_valid or frame_err pulse.
- Frame 0x3C with stop bit low and line held low for 40 cycles -> frame_err 1 cycle; data_out keeps its previous value; busy stays high until the line returns high; no spurious start.
- Frames 0x00 and 0xFF back-to-back, each with a 16-cycle stop bit -> two data_valid pulses 160 cycles apart with data_out 0x00 then 0xFF.
- rst_n=0 for 1 cycle during data bit 3 of 0x55, then the line is idle -> all outputs 0, no pulse, next frame 0x81 received correctly.
- With UART_RX_PARITY_EN: 0x07 with parity 1 -> data_valid and data_out=0x07; 0x07 with parity 0 -> parity_err 1 cycle, no data_valid.
